// File: rtl/mult_sched.sv
// mult_sched: arbitrates two requesters onto one shared add/shift multiplier
// datapath and sequences its control strobes for ITER iterations per product.
module mult_sched #(
  parameter int unsigned ITER = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] Req,
  input  logic       M,
  output logic [1:0] Grant,
  output logic       Sel,
  output logic       Clr_ld,
  output logic       Add,
  output logic       Sub,
  output logic       Shift,
  output logic [1:0] Done,
  output logic       Busy
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADDS,
    SHFT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  // Requester served most recently; a tie on Req=11 goes to the other one.
  logic          last_sel;
  logic          win;

  // Round-robin winner among the current requests (only used in IDLE).
  always_comb begin
    win = 1'b0;
    unique case (Req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_sel;
      default: win = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Iteration counter, grant/select registers and round-robin pointer.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt      <= '0;
      Grant    <= '0;
      Sel      <= 1'b0;
      last_sel <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (Req != 2'b00) begin
            Sel      <= win;
            last_sel <= win;
            Grant    <= win ? 2'b10 : 2'b01;
          end
        end
        LOAD: cnt <= '0;
        SHFT: begin
          if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: Grant <= '0;
        default: ;
      endcase
    end
  end

  // Next-state logic and state-decoded datapath controls; M only gates Add/Sub.
  always_comb begin
    state_nxt = state;
    Clr_ld    = 1'b0;
    Add       = 1'b0;
    Sub       = 1'b0;
    Shift     = 1'b0;
    Done      = '0;
    Busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (Req != 2'b00) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        Clr_ld    = 1'b1;
        state_nxt = ADDS;
      end
      ADDS: begin
        if (cnt == LAST) begin
          Sub = M;
        end else begin
          Add = M;
        end
        state_nxt = SHFT;
      end
      SHFT: begin
        Shift     = 1'b1;
        state_nxt = (cnt == LAST) ? DONE : ADDS;
      end
      DONE: begin
        Done      = Sel ? 2'b10 : 2'b01;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed and randomized checks of mult_sched against a
// cycle-count model of the multiply schedule.
module tb_mult_sched;

  localparam int unsigned ITER = 8;
  localparam int DONE_T = 2 * ITER + 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] Req;
  logic       M;
  logic [1:0] Grant;
  logic       Sel;
  logic       Clr_ld;
  logic       Add;
  logic       Sub;
  logic       Shift;
  logic [1:0] Done;
  logic       Busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: p = cycles since the request was accepted (0 when idle).
  int   p;
  logic m_sel;
  logic m_last;

  mult_sched #(.ITER(ITER)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Req    (Req),
    .M      (M),
    .Grant  (Grant),
    .Sel    (Sel),
    .Clr_ld (Clr_ld),
    .Add    (Add),
    .Sub    (Sub),
    .Shift  (Shift),
    .Done   (Done),
    .Busy   (Busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [1:0] oh(input logic s);
    return s ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Compare every DUT output against the model, mid-cycle.
  task automatic sample();
    logic isadd;
    int   k;
    @(negedge Clk);
    isadd = (p >= 2) && (p <= 2 * ITER) && (p % 2 == 0);
    k     = (p - 2) / 2;
    check("busy",  {1'b0, Busy},   {1'b0, p != 0});
    check("grant", Grant,          (p != 0) ? oh(m_sel) : 2'b00);
    check("sel",   {1'b0, Sel},    {1'b0, m_sel});
    check("clr_ld",{1'b0, Clr_ld}, {1'b0, p == 1});
    check("add",   {1'b0, Add},    {1'b0, isadd && (k < int'(ITER) - 1) && M});
    check("sub",   {1'b0, Sub},    {1'b0, isadd && (k == int'(ITER) - 1) && M});
    check("shift", {1'b0, Shift},  {1'b0, (p >= 3) && (p <= 2 * ITER + 1) && (p % 2 == 1)});
    check("done",  Done,           (p == DONE_T) ? oh(m_sel) : 2'b00);
    check("ctl_onehot0", {1'b0, $countones({Clr_ld, Add, Sub, Shift}) <= 1}, 2'b01);
    check("grant_not11", {1'b0, Grant != 2'b11}, 2'b01);
  endtask

  // Advance the model with this cycle's inputs, then clock the DUT.
  task automatic advance();
    logic w;
    if (!Reset) begin
      p = 0; m_sel = 1'b0; m_last = 1'b1;
    end else if (p == 0) begin
      if (Req != 2'b00) begin
        w = (Req == 2'b01) ? 1'b0 : (Req == 2'b10) ? 1'b1 : ~m_last;
        m_sel = w; m_last = w; p = 1;
      end
    end else if (p == DONE_T) begin
      p = 0;
    end else begin
      p++;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0; Req = 2'b00; M = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("rst_busy",  {1'b0, Busy}, 2'b00);
      check("rst_grant", Grant, 2'b00);
      advance();
    end
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0; Req = 2'b00; M = 1'b0;
    p = 0; m_sel = 1'b0; m_last = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    // Requester 0, M=1 throughout.
    do_reset();
    for (int c = 0; c < 21; c++) begin
      Req = (c < 18) ? 2'b01 : 2'b00; M = 1'b1;
      sample();
      if (c == 1)  check("s1_clr_c1",   {1'b0, Clr_ld}, 2'b01);
      if (c == 14) check("s1_add_c14",  {1'b0, Add},    2'b01);
      if (c == 16) check("s1_sub_c16",  {1'b0, Sub},    2'b01);
      if (c == 17) check("s1_shift_c17",{1'b0, Shift},  2'b01);
      if (c == 18) check("s1_done_c18", Done,           2'b01);
      if (c == 19) check("s1_grant_c19",Grant,          2'b00);
      advance();
    end

    // Requester 1, M=0 throughout.
    for (int c = 0; c < 21; c++) begin
      Req = (c < 18) ? 2'b10 : 2'b00; M = 1'b0;
      sample();
      if (c == 1)  check("s2_sel_c1",   {1'b0, Sel}, 2'b01);
      if (c == 16) check("s2_sub_c16",  {1'b0, Sub}, 2'b00);
      if (c == 18) check("s2_done_c18", Done,        2'b10);
      advance();
    end

    // Both requesting after reset: grants alternate starting with requester 0.
    do_reset();
    for (int c = 0; c < 60; c++) begin
      Req = 2'b11; M = c[0];
      sample();
      if (c == 1)  check("s3_grant_c1",  Grant, 2'b01);
      if (c == 18) check("s3_grant_c18", Grant, 2'b01);
      if (c == 19) check("s3_idle_c19",  Grant, 2'b00);
      if (c == 20) check("s3_grant_c20", Grant, 2'b10);
      if (c == 39) check("s3_grant_c39", Grant, 2'b01);
      advance();
    end
    Req = 2'b00;
    repeat (20) begin sample(); advance(); end

    // Reset pulse mid-operation aborts it without Done.
    for (int c = 0; c < 25; c++) begin
      Req = (c < 7) ? 2'b01 : 2'b00; M = 1'b1;
      Reset = (c == 7) ? 1'b0 : 1'b1;
      sample();
      if (c == 8) begin
        check("s4_busy_c8",  {1'b0, Busy}, 2'b00);
        check("s4_grant_c8", Grant,        2'b00);
        check("s4_ctl_c8",   {1'b0, Clr_ld | Add | Sub | Shift}, 2'b00);
      end
      if (c > 7) check("s4_no_done", Done, 2'b00);
      advance();
    end

    // Request withdrawn at cycle 5 still completes.
    for (int c = 0; c < 21; c++) begin
      Req = (c < 5) ? 2'b01 : 2'b00; M = 1'b1;
      sample();
      if (c == 18) check("s5_done_c18", Done, 2'b01);
      advance();
    end

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      Req   = 2'($urandom_range(0, 3));
      M     = 1'($urandom);
      Reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
